// File: rtl/ysyx_24100006_clint_if.sv
// ----------------------------------------------------------------------------
// ysyx_24100006_clint_if
// AXI-Lite bundle between the SRAM-side arbiter/decoder and the CLINT.
//   AR: araddr, arvalid, arready
//   R : rdata, rresp, rvalid, rready
//   AW: awaddr, awvalid, awready
//   W : wdata, wstrb (only [3:0] meaningful), wvalid, wready
//   B : bresp, bvalid, bready
// master drives requests, slave drives responses.
// ----------------------------------------------------------------------------
interface ysyx_24100006_clint_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_24100006_clint.sv
// ----------------------------------------------------------------------------
// ysyx_24100006_clint
// AXI-Lite slave holding the 64-bit free-running machine timer (mtime).
// 16-byte window at BASE_ADDR, register select on addr[3:2]:
//   0x0 mtime_lo (RO, reading it snapshots mtime[63:32] into hi_shadow)
//   0x4 mtime_hi (RO, returns hi_shadow for a tear-free lo-then-hi pair)
//   0x8 / 0xC mtimecmp lo/hi (RW) only when YSYX_24100006_CLINT_MTIMECMP_EN
//   is defined; otherwise unmapped (SLVERR) and mtip is tied low.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high
//   axi   - AXI-Lite slave (ysyx_24100006_clint_if.slave)
//   mtip  - timer interrupt pending, registered (mtime >= mtimecmp)
// Parameters:
//   BASE_ADDR - window base (decode on addr[31:4])
//   TICK_DIV  - clk cycles per mtime increment (>= 1)
// ----------------------------------------------------------------------------
module ysyx_24100006_clint #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    ysyx_24100006_clint_if.slave        axi,
    output logic                        mtip
);
    localparam int unsigned PS_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // ---------------- timer ----------------
    logic [PS_W-1:0] prescaler;
    logic [63:0]     mtime;
    logic            tick;

    assign tick = (prescaler == PS_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            mtime     <= '0;
        end else if (tick) begin
            prescaler <= '0;
            mtime     <= mtime + 64'd1;
        end else begin
            prescaler <= prescaler + PS_W'(1);
        end
    end

`ifdef YSYX_24100006_CLINT_MTIMECMP_EN
    logic [63:0] mtimecmp;

    function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[i*8 +: 8] = strb[i] ? data[i*8 +: 8] : old[i*8 +: 8];
        return res;
    endfunction
`endif

    // ---------------- read channel ----------------
    typedef enum logic {R_IDLE, R_RESP} r_state_t;
    r_state_t    r_state, r_next;
    logic [31:0] hi_shadow;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        ar_fire, ar_hit, rd_ok;
    logic [1:0]  ar_sel;
    logic [31:0] rd_val;
    logic        arready_c, rvalid_c;

    assign ar_hit  = (axi.araddr[31:4] == BASE_ADDR[31:4]);
    assign ar_sel  = axi.araddr[3:2];
    assign ar_fire = axi.arvalid && (r_state == R_IDLE);

    // Read mux sees the pre-edge register values, so a same-cycle write
    // to the same register is not visible to this read.
    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b0;
        if (ar_hit) begin
            case (ar_sel)
                2'd0: begin rd_val = mtime[31:0];     rd_ok = 1'b1; end
                2'd1: begin rd_val = hi_shadow;       rd_ok = 1'b1; end
`ifdef YSYX_24100006_CLINT_MTIMECMP_EN
                2'd2: begin rd_val = mtimecmp[31:0];  rd_ok = 1'b1; end
                2'd3: begin rd_val = mtimecmp[63:32]; rd_ok = 1'b1; end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    always_comb begin
        r_next    = r_state;
        arready_c = 1'b0;
        rvalid_c  = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready_c = 1'b1;
                if (axi.arvalid) r_next = R_RESP;
            end
            R_RESP: begin
                rvalid_c = 1'b1;
                if (axi.rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            hi_shadow <= '0;
        end else if (ar_fire) begin
            rdata_q <= rd_val;
            rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            if (ar_hit && (ar_sel == 2'd0)) hi_shadow <= mtime[63:32];
        end
    end

    assign axi.arready = arready_c;
    assign axi.rvalid  = rvalid_c;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;

    // ---------------- write channel ----------------
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    w_state_t    w_state, w_next;
    logic        aw_held, w_held;
    logic [31:2] awaddr_q;
    logic [1:0]  bresp_q;
    logic        awready_c, wready_c, bvalid_c;
    logic        aw_fire, w_fire, commit, wr_ok;
    logic [31:2] wr_addr;

    assign awready_c = (w_state == W_IDLE) && !aw_held;
    assign wready_c  = (w_state == W_IDLE) && !w_held;
    assign aw_fire   = axi.awvalid && awready_c;
    assign w_fire    = axi.wvalid && wready_c;
    // A beat is usable either from its holding register or live this cycle.
    assign commit    = (w_state == W_IDLE) && (aw_held || axi.awvalid) && (w_held || axi.wvalid);
    assign wr_addr   = aw_held ? awaddr_q : axi.awaddr[31:2];

`ifdef YSYX_24100006_CLINT_MTIMECMP_EN
    assign wr_ok = (wr_addr[31:4] == BASE_ADDR[31:4]) && wr_addr[3];
`else
    assign wr_ok = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    always_comb begin
        w_next   = w_state;
        bvalid_c = 1'b0;
        case (w_state)
            W_IDLE: if (commit) w_next = W_RESP;
            W_RESP: begin
                bvalid_c = 1'b1;
                if (axi.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            bresp_q  <= RESP_OKAY;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_fire) begin
                aw_held  <= 1'b1;
                awaddr_q <= axi.awaddr[31:2];
            end
            if (w_fire) w_held <= 1'b1;
        end
    end

    assign axi.awready = awready_c;
    assign axi.wready  = wready_c;
    assign axi.bvalid  = bvalid_c;
    assign axi.bresp   = bresp_q;

    logic unused_sig;

`ifdef YSYX_24100006_CLINT_MTIMECMP_EN
    logic [31:0] wdata_q, wr_data;
    logic [3:0]  wstrb_q, wr_strb;

    assign wr_data = w_held ? wdata_q : axi.wdata;
    assign wr_strb = w_held ? wstrb_q : axi.wstrb[3:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdata_q  <= '0;
            wstrb_q  <= '0;
            mtimecmp <= '1;
            mtip     <= 1'b0;
        end else begin
            mtip <= (mtime >= mtimecmp);
            if (w_fire && !commit) begin
                wdata_q <= axi.wdata;
                wstrb_q <= axi.wstrb[3:0];
            end
            if (commit && wr_ok) begin
                if (wr_addr[2]) mtimecmp[63:32] <= apply_strb(mtimecmp[63:32], wr_data, wr_strb);
                else            mtimecmp[31:0]  <= apply_strb(mtimecmp[31:0],  wr_data, wr_strb);
            end
        end
    end

    assign unused_sig = ^{axi.araddr[1:0], axi.awaddr[1:0], axi.wstrb[7:4]};
`else
    assign mtip       = 1'b0;
    assign unused_sig = ^{axi.araddr[1:0], axi.awaddr[1:0], axi.wdata, axi.wstrb, wr_addr};
`endif

endmodule

// File: tb/tb_ysyx_24100006_clint.sv
`timescale 1ns/1ps
module tb_ysyx_24100006_clint;
    localparam logic [31:0] BASE    = 32'h0200_0000;
    localparam logic [27:0] BASE_HI = BASE[31:4];
    localparam int unsigned TD      = 1;
`ifdef YSYX_24100006_CLINT_MTIMECMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mtip;
    int   checks = 0;
    int   errors = 0;
    longint unsigned edges = 0;
    logic [31:0] m_shadow = '0;
    logic [63:0] m_cmp = '1;

    ysyx_24100006_clint_if axi();

    ysyx_24100006_clint #(.BASE_ADDR(BASE), .TICK_DIV(TD)) dut (
        .clk  (clk),
        .reset(reset),
        .axi  (axi),
        .mtip (mtip)
    );

    always #5 clk = ~clk;

    // Reference timer: number of rising edges seen out of reset.
    always @(posedge clk or posedge reset)
        if (reset) edges <= 0;
        else       edges <= edges + 1;

    function automatic logic [63:0] model_mtime();
        return 64'(edges / TD);
    endfunction

    function automatic void model_read(input logic [31:0] addr, input logic [63:0] mt,
                                       output logic [31:0] d, output logic [1:0] r);
        d = '0;
        r = 2'b10;
        if (addr[31:4] == BASE_HI) begin
            case (addr[3:2])
                2'd0: begin d = mt[31:0]; r = 2'b00; m_shadow = mt[63:32]; end
                2'd1: begin d = m_shadow; r = 2'b00; end
                2'd2: if (CMP_EN) begin d = m_cmp[31:0];  r = 2'b00; end
                default: if (CMP_EN) begin d = m_cmp[63:32]; r = 2'b00; end
            endcase
        end
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] d,
                                               input logic [3:0] s);
        if (CMP_EN && addr[31:4] == BASE_HI && addr[3]) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) begin
                    if (addr[2]) m_cmp[32 + 8*i +: 8] = d[8*i +: 8];
                    else         m_cmp[8*i +: 8]      = d[8*i +: 8];
                end
            return 2'b00;
        end
        return 2'b10;
    endfunction

    task automatic idle_bus();
        axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0;
        axi.wstrb = '0;  axi.wvalid = 1'b0;  axi.bready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_bus();
        m_shadow = '0;
        m_cmp = '1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int rdly,
                            output logic [63:0] pre, output logic [31:0] d, output logic [1:0] r,
                            output bit lat_ok, output bit hold_ok, output bit done_ok);
        int n;
        lat_ok = 0; hold_ok = 1; done_ok = 0; pre = '0; d = '0; r = '0;
        axi.araddr = addr; axi.arvalid = 1'b1; axi.rready = 1'b0;
        n = 0;
        while (axi.arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (axi.arready !== 1'b1) begin axi.arvalid = 1'b0; return; end
        pre = model_mtime();
        @(negedge clk);
        axi.arvalid = 1'b0;
        lat_ok = (axi.rvalid === 1'b1) && (axi.arready === 1'b0);
        d = axi.rdata;
        r = axi.rresp;
        repeat (rdly) begin
            @(negedge clk);
            if (axi.rvalid !== 1'b1 || axi.arready !== 1'b0 || axi.rdata !== d || axi.rresp !== r)
                hold_ok = 0;
        end
        axi.rready = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0;
        done_ok = (axi.rvalid === 1'b0) && (axi.arready === 1'b1);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int awd, input int wd, input int bdly,
                             output logic [1:0] r, output bit lat_ok, output bit rdy_ok,
                             output bit hold_ok, output bit done_ok);
        bit aw_done, w_done, aw_hs, w_hs;
        int c;
        aw_done = 0; w_done = 0; c = 0;
        lat_ok = 0; rdy_ok = 1; hold_ok = 1; done_ok = 0; r = '0;
        axi.awaddr = addr; axi.wdata = data;
        axi.wstrb = {4'($urandom_range(15)), strb};
        axi.bready = 1'b0;
        while (!(aw_done && w_done) && c < 50) begin
            axi.awvalid = (c >= awd) && !aw_done;
            axi.wvalid  = (c >= wd) && !w_done;
            if (axi.bvalid !== 1'b0) rdy_ok = 0;
            if (aw_done && axi.awready !== 1'b0) rdy_ok = 0;
            if (w_done && axi.wready !== 1'b0) rdy_ok = 0;
            aw_hs = axi.awvalid && (axi.awready === 1'b1);
            w_hs  = axi.wvalid && (axi.wready === 1'b1);
            @(negedge clk);
            c++;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
        end
        axi.awvalid = 1'b0;
        axi.wvalid = 1'b0;
        if (!(aw_done && w_done)) return;
        lat_ok = (axi.bvalid === 1'b1) && (axi.awready === 1'b0) && (axi.wready === 1'b0);
        r = axi.bresp;
        repeat (bdly) begin
            @(negedge clk);
            if (axi.bvalid !== 1'b1 || axi.bresp !== r) hold_ok = 0;
        end
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        done_ok = (axi.bvalid === 1'b0) && (axi.awready === 1'b1) && (axi.wready === 1'b1);
    endtask

    task automatic test_reset();
        logic [8:0] got;
        reset = 1'b1;
        idle_bus();
        repeat (2) @(negedge clk);
        got = {axi.arready, axi.awready, axi.wready, axi.rvalid, axi.bvalid,
               |axi.rdata, |axi.rresp, |axi.bresp, mtip};
        checks++;
        if (got !== 9'b111_00_0000) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", got, 9'b111_00_0000);
        end
        reset = 1'b0;
    endtask

    task automatic test_first_read();
        logic [63:0] pre; logic [31:0] d; logic [1:0] r; bit lat, hold, done;
        repeat (10) @(negedge clk);
        axi_read(BASE, 0, pre, d, r, lat, hold, done);
        m_shadow = pre[63:32];
        checks++; if (d !== 32'd10) begin errors++; $display("FAIL first_rdata: got %0d expected 10", d); end
        checks++; if (r !== 2'b00) begin errors++; $display("FAIL first_rresp: got %b expected 00", r); end
        checks++; if (lat !== 1'b1) begin errors++; $display("FAIL first_latency: got %b expected 1", lat); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL first_done: got %b expected 1", done); end
    endtask

    task automatic test_shadow();
        logic [63:0] pre; logic [31:0] d, ed; logic [1:0] r, er; bit lat, hold, done;
        axi_read(BASE, 0, pre, d, r, lat, hold, done);
        model_read(BASE, pre, ed, er);
        checks++; if (d !== ed || r !== er) begin errors++; $display("FAIL shadow_lo: got %h/%b expected %h/%b", d, r, ed, er); end
        repeat (5) @(negedge clk);
        axi_read(BASE + 32'h4, 0, pre, d, r, lat, hold, done);
        model_read(BASE + 32'h4, pre, ed, er);
        checks++; if (d !== ed || r !== er) begin errors++; $display("FAIL shadow_hi: got %h/%b expected %h/%b", d, r, ed, er); end
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL shadow_hi_zero: got %h expected 0", d); end
    endtask

    task automatic test_unmapped();
        logic [63:0] pre; logic [31:0] d, ed; logic [1:0] r, er; bit lat, rdy, hold, done;
        axi_read(BASE + 32'h10, 0, pre, d, r, lat, hold, done);
        checks++; if (d !== 32'd0 || r !== 2'b10) begin errors++; $display("FAIL oow_read: got %h/%b expected 0/10", d, r); end
        axi_write(BASE, 32'h1234, 4'hF, 0, 0, 0, r, lat, rdy, hold, done);
        checks++; if (r !== 2'b10) begin errors++; $display("FAIL ro_write_bresp: got %b expected 10", r); end
        checks++; if (lat !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL ro_write_hs: got %b%b expected 11", lat, done); end
        axi_read(BASE, 0, pre, d, r, lat, hold, done);
        model_read(BASE, pre, ed, er);
        checks++; if (d !== ed || r !== er) begin errors++; $display("FAIL mtime_after_ro_write: got %h/%b expected %h/%b", d, r, ed, er); end
    endtask

    task automatic test_rready_hold();
        logic [63:0] pre; logic [31:0] d, ed; logic [1:0] r, er; bit lat, hold, done;
        axi_read(BASE, 5, pre, d, r, lat, hold, done);
        model_read(BASE, pre, ed, er);
        checks++; if (d !== ed || r !== er) begin errors++; $display("FAIL hold_data: got %h/%b expected %h/%b", d, r, ed, er); end
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL hold_stable: got %b expected 1", hold); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL hold_done: got %b expected 1", done); end
        @(negedge clk);
        checks++; if (axi.rvalid !== 1'b0) begin errors++; $display("FAIL hold_single: got %b expected 0", axi.rvalid); end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] r, er; bit lat, rdy, hold, done;
        axi_write(BASE + 32'h8, 32'hCAFE_0001, 4'hF, 3, 0, 2, r, lat, rdy, hold, done);
        er = model_write(BASE + 32'h8, 32'hCAFE_0001, 4'hF);
        checks++; if (r !== er) begin errors++; $display("FAIL wfirst_bresp: got %b expected %b", r, er); end
        checks++; if (lat !== 1'b1) begin errors++; $display("FAIL wfirst_latency: got %b expected 1", lat); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL wfirst_ready_drop: got %b expected 1", rdy); end
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL wfirst_bhold: got %b expected 1", hold); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wfirst_done: got %b expected 1", done); end
        @(negedge clk);
        checks++; if (axi.bvalid !== 1'b0) begin errors++; $display("FAIL wfirst_single: got %b expected 0", axi.bvalid); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] a, wd, ed, d; logic [1:0] er, eb, r; logic [63:0] pre; bit lat, hold, done;
        a = CMP_EN ? BASE + 32'h8 : BASE;
        wd = $urandom;
        @(negedge clk);
        model_read(a, model_mtime(), ed, er);
        eb = model_write(a, wd, 4'hF);
        axi.araddr = a; axi.arvalid = 1'b1;
        axi.awaddr = a; axi.awvalid = 1'b1;
        axi.wdata = wd; axi.wstrb = 8'h0F; axi.wvalid = 1'b1;
        @(negedge clk);
        axi.arvalid = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        checks++; if (axi.rvalid !== 1'b1 || axi.bvalid !== 1'b1) begin errors++; $display("FAIL same_valids: got %b%b expected 11", axi.rvalid, axi.bvalid); end
        checks++; if (axi.rdata !== ed || axi.rresp !== er) begin errors++; $display("FAIL same_read_old: got %h/%b expected %h/%b", axi.rdata, axi.rresp, ed, er); end
        checks++; if (axi.bresp !== eb) begin errors++; $display("FAIL same_bresp: got %b expected %b", axi.bresp, eb); end
        axi.rready = 1'b1; axi.bready = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0; axi.bready = 1'b0;
        checks++; if (axi.rvalid !== 1'b0 || axi.bvalid !== 1'b0) begin errors++; $display("FAIL same_done: got %b%b expected 00", axi.rvalid, axi.bvalid); end
        axi_read(a, 0, pre, d, r, lat, hold, done);
        model_read(a, pre, ed, er);
        checks++; if (d !== ed || r !== er) begin errors++; $display("FAIL same_readback: got %h/%b expected %h/%b", d, r, ed, er); end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, d, ed; logic [3:0] s; logic [1:0] r, er; logic [63:0] pre;
        bit lat, rdy, hold, done;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(5))
                0: a = BASE;
                1: a = BASE + 32'h4;
                2: a = BASE + 32'h8;
                3: a = BASE + 32'hC;
                4: a = BASE + 32'h10 * (1 + $urandom_range(200)) + 32'(4 * $urandom_range(3));
                default: a = {1'b1, 31'($urandom)};
            endcase
            if ($urandom_range(1) == 0) begin
                axi_read(a, $urandom_range(3), pre, d, r, lat, hold, done);
                model_read(a, pre, ed, er);
                checks++;
                if (d !== ed || r !== er || !lat || !hold || !done) begin
                    errors++;
                    $display("FAIL rand_read[%0d] @%h: got %h/%b lhd=%b%b%b expected %h/%b lhd=111", i, a, d, r, lat, hold, done, ed, er);
                end
            end else begin
                wd = $urandom;
                s = 4'($urandom_range(15));
                axi_write(a, wd, s, $urandom_range(3), $urandom_range(3), $urandom_range(3), r, lat, rdy, hold, done);
                er = model_write(a, wd, s);
                checks++;
                if (r !== er || !lat || !rdy || !hold || !done) begin
                    errors++;
                    $display("FAIL rand_write[%0d] @%h: got %b lrhd=%b%b%b%b expected %b lrhd=1111", i, a, r, lat, rdy, hold, done, er);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        axi.araddr = BASE; axi.arvalid = 1'b1;
        axi.awaddr = BASE + 32'h4; axi.awvalid = 1'b1;
        axi.wdata = 32'h55; axi.wstrb = 8'h0F; axi.wvalid = 1'b1;
        @(negedge clk);
        idle_bus();
        checks++; if (axi.rvalid !== 1'b1 || axi.bvalid !== 1'b1) begin errors++; $display("FAIL abort_pending: got %b%b expected 11", axi.rvalid, axi.bvalid); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({axi.rvalid, axi.bvalid, axi.arready, axi.awready, axi.wready} !== 5'b00111 || axi.rdata !== 32'd0) begin
            errors++; $display("FAIL abort_async: got %b rdata=%h expected 00111 rdata=0",
                               {axi.rvalid, axi.bvalid, axi.arready, axi.awready, axi.wready}, axi.rdata);
        end
        m_shadow = '0;
        m_cmp = '1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (axi.rvalid !== 1'b0 || axi.bvalid !== 1'b0) begin errors++; $display("FAIL abort_dropped: got %b%b expected 00", axi.rvalid, axi.bvalid); end
    endtask

    task automatic test_mtip();
        logic [1:0] r, er; bit lat, rdy, hold, done, exp_m;
        do_reset();
        axi_write(BASE + 32'h8, 32'd40, 4'hF, 0, 0, 0, r, lat, rdy, hold, done);
        er = model_write(BASE + 32'h8, 32'd40, 4'hF);
        checks++; if (r !== er) begin errors++; $display("FAIL mtip_cmp_lo_bresp: got %b expected %b", r, er); end
        axi_write(BASE + 32'hC, 32'd0, 4'hF, 0, 0, 0, r, lat, rdy, hold, done);
        er = model_write(BASE + 32'hC, 32'd0, 4'hF);
        checks++; if (r !== er) begin errors++; $display("FAIL mtip_cmp_hi_bresp: got %b expected %b", r, er); end
        while (edges < 48) begin
            @(negedge clk);
            exp_m = (edges >= 1) && (64'((edges - 1) / TD) >= m_cmp);
            checks++;
            if (mtip !== exp_m) begin errors++; $display("FAIL mtip[mtime=%0d]: got %b expected %b", model_mtime(), mtip, exp_m); end
        end
    endtask

    initial begin
        idle_bus();
        test_reset();
        test_first_read();
        test_shadow();
        test_unmapped();
        test_rready_hold();
        test_w_before_aw();
        test_same_cycle();
        test_random();
        test_reset_abort();
        test_mtip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
